// File: rtl/button_led_controller.sv
// rtl/button_led_controller.sv - debounced push buttons driving LEDs with short/long press events and blink mode
module button_led_controller #(
    parameter int NUM_BUTTONS       = 3,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int BLINK_HALF_PERIOD = 12500000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic [NUM_BUTTONS-1:0] led,
    output logic [NUM_BUTTONS-1:0] short_press,
    output logic [NUM_BUTTONS-1:0] long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSED   = 2'd1,
        HELD_LONG = 2'd2
    } state_t;

    logic [1:0] rst_sync;
    logic       rst_s_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_s_n = rst_sync[1];

    logic [NUM_BUTTONS-1:0] sync_ff [SYNC_STAGES];
    logic [NUM_BUTTONS-1:0] sync;

    always_ff @(posedge clock or negedge rst_s_n) begin
        if (!rst_s_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '1;
        end else begin
            sync_ff[0] <= button_n;
            for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
        end
    end
    assign sync = sync_ff[SYNC_STAGES-1];

    logic [DW-1:0]          deb_cnt_q [NUM_BUTTONS];
    logic [DW-1:0]          deb_cnt_d [NUM_BUTTONS];
    logic [HW-1:0]          hold_cnt_q [NUM_BUTTONS];
    logic [HW-1:0]          hold_cnt_d [NUM_BUTTONS];
    state_t                 state_q [NUM_BUTTONS];
    state_t                 state_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] deb_level_q, deb_level_d;
    logic [NUM_BUTTONS-1:0] led_state_q, led_state_d;
    logic [NUM_BUTTONS-1:0] blink_en_q, blink_en_d;
    logic [NUM_BUTTONS-1:0] led_d, short_d, long_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_phase_q, blink_phase_d;

    always_ff @(posedge clock or negedge rst_s_n) begin
        if (!rst_s_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
                state_q[i]    <= RELEASED;
            end
            deb_level_q   <= '1;
            led_state_q   <= '0;
            blink_en_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led           <= '0;
            short_press   <= '0;
            long_press    <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
            deb_level_q   <= deb_level_d;
            led_state_q   <= led_state_d;
            blink_en_q    <= blink_en_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led           <= led_d;
            short_press   <= short_d;
            long_press    <= long_d;
        end
    end

    // The press FSM reacts to the debouncer's next level so pulses land on the same edge the level is accepted.
    always_comb begin
        deb_level_d   = deb_level_q;
        led_state_d   = led_state_q;
        blink_en_d    = blink_en_q;
        short_d       = '0;
        long_d        = '0;
        led_d         = '0;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            deb_cnt_d[i]  = '0;
            hold_cnt_d[i] = hold_cnt_q[i];
            state_d[i]    = state_q[i];
            if (sync[i] != deb_level_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_level_d[i] = sync[i];
                else                                          deb_cnt_d[i]   = deb_cnt_q[i] + 1'b1;
            end
            case (state_q[i])
                RELEASED: begin
                    if (!deb_level_d[i]) begin
                        state_d[i]    = PRESSED;
                        hold_cnt_d[i] = '0;
                    end
                end
                PRESSED: begin
                    if (deb_level_d[i]) begin
                        state_d[i]     = RELEASED;
                        short_d[i]     = 1'b1;
                        led_state_d[i] = ~led_state_q[i];
                    end else if (hold_cnt_q[i] == HW'(LONG_PRESS_CYCLES - 1)) begin
                        state_d[i]    = HELD_LONG;
                        long_d[i]     = 1'b1;
                        blink_en_d[i] = ~blink_en_q[i];
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    end
                end
                HELD_LONG: begin
                    if (deb_level_d[i]) state_d[i] = RELEASED;
                end
                default: state_d[i] = RELEASED;
            endcase
            led_d[i] = blink_en_d[i] ? blink_phase_d : led_state_d[i];
        end
    end

endmodule

// File: tb/tb_button_led_controller.sv
// tb/tb_button_led_controller.sv - directed bench with a per-cycle behavioural model of button_led_controller
module tb_button_led_controller;
    localparam int N     = 3;
    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int BLINK = 8;

    logic         clock    = 1'b0;
    logic         reset_n  = 1'b1;
    logic [N-1:0] button_n = '1;
    logic [N-1:0] led, short_press, long_press;

    button_led_controller #(
        .NUM_BUTTONS(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONG), .BLINK_HALF_PERIOD(BLINK)
    ) dut (
        .clock(clock), .reset_n(reset_n), .button_n(button_n),
        .led(led), .short_press(short_press), .long_press(long_press)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [N-1:0] samp_btn = '1;
    logic         samp_rst = 1'b0;
    logic         run_cmp = 1'b0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        samp_btn <= button_n;
        samp_rst <= reset_n;
    end

    logic [N-1:0] m_h1, m_h2, m_lvl, m_led_state, m_blink_en, m_pressed, m_long_done;
    logic [N-1:0] m_short, m_long, m_led;
    int m_run [N];
    int m_age [N];
    int m_edges;
    int rcount;
    int short_cnt [N];
    int long_cnt [N];
    int short_cyc [N];
    int long_cyc [N];

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_h1 = '1; m_h2 = '1; m_lvl = '1;
        m_led_state = '0; m_blink_en = '0; m_pressed = '0; m_long_done = '0;
        m_short = '0; m_long = '0; m_led = '0;
        m_edges = 0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    // One active clock edge: button seen two edges late, accepted after DEB consecutive differing samples.
    task automatic model_step(input logic [N-1:0] b);
        logic seen;
        bit   commit;
        m_short = '0;
        m_long  = '0;
        for (int i = 0; i < N; i++) begin
            seen    = m_h2[i];
            m_h2[i] = m_h1[i];
            m_h1[i] = b[i];
            commit  = 0;
            if (seen != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = seen;
                    m_run[i] = 0;
                    commit   = 1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (commit && !m_lvl[i]) begin
                m_pressed[i]   = 1'b1;
                m_long_done[i] = 1'b0;
                m_age[i]       = 0;
            end else if (commit && m_lvl[i]) begin
                if (m_pressed[i] && !m_long_done[i]) begin
                    m_short[i]     = 1'b1;
                    m_led_state[i] = ~m_led_state[i];
                end
                m_pressed[i] = 1'b0;
            end else if (m_pressed[i] && !m_long_done[i]) begin
                m_age[i]++;
                if (m_age[i] == LONG) begin
                    m_long[i]      = 1'b1;
                    m_blink_en[i]  = ~m_blink_en[i];
                    m_long_done[i] = 1'b1;
                end
            end
        end
        m_edges++;
        for (int i = 0; i < N; i++)
            m_led[i] = m_blink_en[i] ? (((m_edges / BLINK) % 2) == 1) : m_led_state[i];
    endtask

    always @(negedge clock) begin
        if (run_cmp) begin
            if (!reset_n) begin
                model_reset();
                rcount = 0;
            end else begin
                if (samp_rst) rcount++;
                if (rcount >= 3) model_step(samp_btn);
            end
            check_vec("led", led, m_led);
            check_vec("short_press", short_press, m_short);
            check_vec("long_press", long_press, m_long);
            for (int i = 0; i < N; i++) begin
                if (short_press[i] === 1'b1) begin short_cnt[i]++; short_cyc[i] = cyc; end
                if (long_press[i] === 1'b1)  begin long_cnt[i]++;  long_cyc[i]  = cyc; end
            end
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        int t0;
        int t1;
        int hi;
        for (int i = 0; i < N; i++) begin
            short_cnt[i] = 0; long_cnt[i] = 0; short_cyc[i] = -1; long_cyc[i] = -1;
        end
        rcount = 0;
        #1;
        reset_n = 1'b0;
        run_cmp = 1'b1;
        go(3);
        reset_n = 1'b1;
        go(100);
        check_int("t1_no_short", short_cnt[0] + short_cnt[1] + short_cnt[2], 0);
        check_int("t1_no_long", long_cnt[0] + long_cnt[1] + long_cnt[2], 0);
        check_vec("t1_led", led, 3'b000);

        button_n[0] = 1'b0; go(10);
        button_n[0] = 1'b1; t0 = cyc; go(12);
        check_int("t2_short_latency", short_cyc[0] - t0, 6);
        check_int("t2_short_count", short_cnt[0], 1);
        check_vec("t2_led_on", led, 3'b001);
        button_n[0] = 1'b0; go(10);
        button_n[0] = 1'b1; go(12);
        check_int("t2_short_count2", short_cnt[0], 2);
        check_vec("t2_led_off", led, 3'b000);

        for (int k = 0; k < 10; k++) begin
            button_n[1] = 1'b0; go(3);
            button_n[1] = 1'b1; go(3);
        end
        go(10);
        check_int("t3_glitch_short", short_cnt[1], 0);
        check_int("t3_glitch_long", long_cnt[1], 0);
        check_vec("t3_led", led, 3'b000);

        button_n[2] = 1'b0; t0 = cyc; go(40);
        button_n[2] = 1'b1; go(12);
        check_int("t4_long_latency", long_cyc[2] - t0, 26);
        check_int("t4_long_count", long_cnt[2], 1);
        check_int("t4_no_short", short_cnt[2], 0);
        hi = 0;
        repeat (16) begin
            @(negedge clock);
            hi += int'(led[2]);
        end
        check_int("t4_blink_duty", hi, 8);
        go(1);
        button_n[2] = 1'b0; go(40);
        button_n[2] = 1'b1; go(12);
        check_int("t4_long_count2", long_cnt[2], 2);
        check_vec("t4_led_restored", led, 3'b000);

        button_n[1:0] = 2'b00; go(10);
        button_n[1:0] = 2'b11; t0 = cyc; go(12);
        check_int("t5_short0_latency", short_cyc[0] - t0, 6);
        check_int("t5_short1_latency", short_cyc[1] - t0, 6);
        check_vec("t5_led", led, 3'b011);

        button_n[0] = 1'b0; go(15);
        reset_n = 1'b0;
        #1;
        check_vec("t6_reset_led", led, 3'b000);
        check_vec("t6_reset_short", short_press, 3'b000);
        check_vec("t6_reset_long", long_press, 3'b000);
        go(5);
        reset_n = 1'b1; go(12);
        button_n[0] = 1'b1; t1 = cyc; go(12);
        check_int("t6_short_latency", short_cyc[0] - t1, 6);
        check_int("t6_short_count", short_cnt[0], 4);
        check_int("t6_no_long", long_cnt[0], 0);
        check_vec("t6_led", led, 3'b001);

        go(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
